mem_access_sequencer: RTL
=========================

Name: mem_access_sequencer

Overview:
Sequences single memory transactions for the board-level front end. It captures a command (clear / read / write) when the IO front end pulses its done strobe, then drives a pipelined read/write memory port with a waitrequest/readdatavalid handshake. It returns read data and a ready flag to the front end. Clear mode sweeps a parameterised address range, writing zeros. All commands pass through this one block, so the front end never touches the memory port directly.

Parameters:
ADDR_W, 25, width of the memory word address
DATA_W, 16, width of the memory data word
CLEAR_WORDS, 1024, number of words zeroed by a clear command (addresses 0 .. CLEAR_WORDS-1); must be >= 1
TIMEOUT, 255, maximum cycles spent waiting for any single handshake step before aborting; must be >= 1

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
io_done  input  1  command strobe from front end; a rising edge starts a command
mode  input  2  command code: 00 clear, 01 read, 10 write, 11 none
io_addr  input  ADDR_W  target address for read/write
io_wdata  input  DATA_W  write data
mem_done  output  1  high when idle and ready for a command
mem_out  output  DATA_W  data from the last completed read
err  output  1  sticky timeout flag
avm_address  output  ADDR_W  memory address
avm_writedata  output  DATA_W  memory write data
avm_read  output  1  read request strobe
avm_write  output  1  write request strobe
avm_waitrequest  input  1  memory stall; a request is accepted on the clk edge where the strobe is high and this is low
avm_readdata  input  DATA_W  read return data
avm_readdatavalid  input  1  qualifies avm_readdata

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. On reset all outputs are driven immediately: mem_done=1, mem_out=0, err=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, state IDLE, io_done_q=0.
- Edge detect: io_done_q is registered every cycle. start = io_done & ~io_done_q.
- States are IDLE, WR_REQ, RD_REQ, RD_WAIT, CLR_REQ. All outputs are registered.
- IDLE:
  - start with mode 10 -> latch io_addr/io_wdata into avm_address/avm_writedata, avm_write<=1, mem_done<=0, err<=0, go WR_REQ.
  - start with mode 01 -> latch io_addr, avm_read<=1, mem_done<=0, err<=0, go RD_REQ.
  - start with mode 00 -> avm_address<=0, avm_writedata<=0, avm_write<=1, mem_done<=0, err<=0, go CLR_REQ.
  - start with mode 11 -> ignored; remain IDLE, mem_done stays 1, err unchanged.
  - Latency: the strobe is visible on the first clk edge after the one that sampled start.
- WR_REQ: hold all request outputs stable while avm_waitrequest=1. On accept: avm_write<=0, mem_done<=1, go IDLE.
- RD_REQ: hold while stalled. On accept: avm_read<=0, go RD_WAIT.
- RD_WAIT: on avm_readdatavalid=1: mem_out<=avm_readdata, mem_done<=1, go IDLE. Minimum read turnaround is accept edge + 1 cycle.
- CLR_REQ:
  - On accept with avm_address < CLEAR_WORDS-1: avm_address<=avm_address+1 and avm_write stays high (back-to-back writes, no bubble).
  - On accept with avm_address == CLEAR_WORDS-1: avm_write<=0, mem_done<=1, go IDLE.
  - The address counter is ADDR_W wide and never wraps within a clear.
- Timeout:
  - A wait counter resets to 0 on entry to any non-IDLE state and on every accept or readdatavalid.
  - It increments each cycle spent in WR_REQ, RD_REQ, RD_WAIT or CLR_REQ without progress.
  - When it reaches TIMEOUT: strobes <=0, err<=1, mem_done<=1, go IDLE. mem_out is unchanged. Clear progress is abandoned and not resumed.
- Busy rules:
  - start while not IDLE is dropped, not queued.
  - mode/io_addr/io_wdata changes after capture have no effect.
  - avm_readdatavalid outside RD_WAIT is ignored.
- Simultaneous events:
  - In RD_WAIT, readdatavalid on the same edge the counter would hit TIMEOUT -> data is captured, err stays 0.
  - Accept on the timeout edge -> the accept wins.
- Reset mid-operation: strobes drop asynchronously, no completion is reported, mem_out returns to 0.

Test Plan:
- Write, no stall: mode=10, io_addr=0x0001234, io_wdata=0xBEEF, pulse io_done, waitrequest=0 -> avm_write high exactly 1 cycle with address 0x0001234 / data 0xBEEF; mem_done low 1 cycle, then 1.
- Read with stall and latency: mode=01, addr=0x1000005, waitrequest high 3 cycles, readdatavalid 2 cycles after accept with data 0x5A5A -> avm_read high 4 cycles, mem_out=0x5A5A, mem_done returns 1 on the capture edge.
- Clear, CLEAR_WORDS=4: mode=00 with one stall on the third write -> addresses 0,1,2,2,3 presented, writedata=0, 4 accepts total, then IDLE with mem_done=1.
- Timeout, TIMEOUT=8: read with waitrequest held high -> avm_read drops after 8 waiting cycles, err=1, mem_done=1, mem_out unchanged. A following write clears err.
- Busy/ignore: second io_done edge during RD_WAIT, mode=11 start in IDLE, stray readdatavalid in IDLE -> no new transaction, mem_out unchanged, io_done held high generates no second start.
- Reset mid-clear: assert rst_n=0 while in CLR_REQ -> avm_write=0 with no clock edge needed; after release mem_done=1, err=0, mem_out=0.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Single-transaction sequencer between the IO front end and a pipelined memory port.
// Captures clear/read/write commands on the io_done rising edge and runs the handshake.
module mem_access_sequencer #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int CLEAR_WORDS = 1024,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              io_done,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_out,
    output logic              err,
    output logic [ADDR_W-1:0] avm_address,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_read,
    output logic              avm_write,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_CLR_REQ = 3'd4;

    localparam logic [1:0] MODE_CLEAR = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_WORDS - 1);

    logic [2:0]        state_q, state_d;
    logic              io_done_q;
    logic              mem_done_q, mem_done_d;
    logic [DATA_W-1:0] mem_out_q, mem_out_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic start;
    logic accept;
    logic timeout_hit;

    assign start       = io_done & ~io_done_q;
    assign accept      = (read_q | write_q) & ~avm_waitrequest;
    // The stalled cycle that would bring the counter to TIMEOUT aborts instead.
    assign timeout_hit = (wait_cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        mem_done_d = mem_done_q;
        mem_out_d  = mem_out_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        read_d     = read_q;
        write_d    = write_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                wait_cnt_d = '0;
                if (start) begin
                    case (mode)
                        MODE_WRITE: begin
                            addr_d     = io_addr;
                            wdata_d    = io_wdata;
                            write_d    = 1'b1;
                            mem_done_d = 1'b0;
                            err_d      = 1'b0;
                            state_d    = S_WR_REQ;
                        end
                        MODE_READ: begin
                            addr_d     = io_addr;
                            read_d     = 1'b1;
                            mem_done_d = 1'b0;
                            err_d      = 1'b0;
                            state_d    = S_RD_REQ;
                        end
                        MODE_CLEAR: begin
                            addr_d     = '0;
                            wdata_d    = '0;
                            write_d    = 1'b1;
                            mem_done_d = 1'b0;
                            err_d      = 1'b0;
                            state_d    = S_CLR_REQ;
                        end
                        default: ;
                    endcase
                end
            end
            S_WR_REQ: begin
                if (accept) begin
                    write_d    = 1'b0;
                    mem_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (timeout_hit) begin
                    write_d    = 1'b0;
                    err_d      = 1'b1;
                    mem_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RD_REQ: begin
                if (accept) begin
                    read_d     = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = S_RD_WAIT;
                end else if (timeout_hit) begin
                    read_d     = 1'b0;
                    err_d      = 1'b1;
                    mem_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    mem_out_d  = avm_readdata;
                    mem_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    mem_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_CLR_REQ: begin
                if (accept) begin
                    wait_cnt_d = '0;
                    if (addr_q == CLR_LAST) begin
                        write_d    = 1'b0;
                        mem_done_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else if (timeout_hit) begin
                    write_d    = 1'b0;
                    err_d      = 1'b1;
                    mem_done_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                read_d     = 1'b0;
                write_d    = 1'b0;
                mem_done_d = 1'b1;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            io_done_q  <= 1'b0;
            mem_done_q <= 1'b1;
            mem_out_q  <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            io_done_q  <= io_done;
            mem_done_q <= mem_done_d;
            mem_out_q  <= mem_out_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            read_q     <= read_d;
            write_q    <= write_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign mem_done      = mem_done_q;
    assign mem_out       = mem_out_q;
    assign err           = err_q;
    assign avm_address   = addr_q;
    assign avm_writedata = wdata_q;
    assign avm_read      = read_q;
    assign avm_write     = write_q;

endmodule
